// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding,
// the default bus timeout and the user-project register map that the
// register slave decodes.
package wbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

  localparam int unsigned WBM_DEF_TIMEOUT_CYCLES = 32'd255;

  // User-project register map (byte addresses)
  localparam logic [31:0] UP_BASE      = 32'h3000_0000;
  localparam logic [31:0] UP_PWM0_RISE = UP_BASE + 32'd0;
  localparam logic [31:0] UP_PWM0_FALL = UP_BASE + 32'd4;
  localparam logic [31:0] UP_PWM1_RISE = UP_BASE + 32'd8;
  localparam logic [31:0] UP_PWM1_FALL = UP_BASE + 32'd12;
  localparam logic [31:0] UP_PWM2_RISE = UP_BASE + 32'd16;
  localparam logic [31:0] UP_PWM2_FALL = UP_BASE + 32'd20;
  localparam logic [31:0] UP_PWM3_RISE = UP_BASE + 32'd24;
  localparam logic [31:0] UP_PWM3_FALL = UP_BASE + 32'd28;
  localparam logic [31:0] UP_ADC0      = UP_BASE + 32'd32;
  localparam logic [31:0] UP_ADC1      = UP_BASE + 32'd36;
  localparam logic [31:0] UP_STATUS    = UP_BASE + 32'd40;
  localparam logic [31:0] UP_CTRL      = UP_BASE + 32'd60;

  // Word index of a user-project register within the 16-word window
  function automatic logic [3:0] up_word_index(input logic [31:0] adr);
    return adr[5:2];
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Bundle of the command stream, response stream and Wishbone classic
// initiator signals. "master" is the view of wb_cmd_master, "slave" is the
// view of whatever sits around it (sequencer plus bus slave).
interface wb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;
  logic [SEL_WIDTH-1:0]  cmd_sel;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_err;

  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [SEL_WIDTH-1:0]  wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [DATA_WIDTH-1:0] wbm_dat_o;
  logic [DATA_WIDTH-1:0] wbm_dat_i;
  logic                  wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_cmd_master_timeout_timer.sv
// Bus-cycle watchdog: counts BUS cycles without an acknowledge and flags
// the terminal count (TIMEOUT_CYCLES-1). Only built with WBM_TIMEOUT_EN.
module wbm_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  // TIMEOUT_CYCLES >= 2, so TIMEOUT_CYCLES-1 always fits in $clog2 bits
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Cycle counter: cleared on bus entry, saturates at the terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one bus cycle, one response
// out. Non-pipelined, cyc and stb are always driven from the same flop.
// Optional feature macro: WBM_TIMEOUT_EN (forced error completion after
// TIMEOUT_CYCLES cycles without acknowledge).
module wb_cmd_master
  import wbm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = WBM_DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_cmd_master_if.master        bus,
  output logic                   busy
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  wbm_state_e state, next_state;

  logic                  cyc_r, cyc_nxt;
  logic                  we_r, we_nxt;
  logic [ADDR_WIDTH-1:0] adr_r, adr_nxt;
  logic [DATA_WIDTH-1:0] dat_r, dat_nxt;
  logic [SEL_WIDTH-1:0]  sel_r, sel_nxt;
  logic                  rsp_valid_r, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_dat_r, rsp_dat_nxt;
  logic                  rsp_err_r, rsp_err_nxt;

  logic accept;
  logic timed_out;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;

`ifdef WBM_TIMEOUT_EN
  logic expired;

  wbm_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  ((state == ST_BUS) && !bus.wbm_ack_i),
    .expired (expired)
  );

  // An ack on the terminal-count edge wins over the timeout
  assign timed_out = (state == ST_BUS) && !bus.wbm_ack_i && expired;
`else
  assign timed_out = 1'b0;
`endif

  assign bus.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign bus.wbm_cyc_o = cyc_r;
  assign bus.wbm_stb_o = cyc_r;
  assign bus.wbm_we_o  = we_r;
  assign bus.wbm_adr_o = adr_r;
  assign bus.wbm_dat_o = dat_r;
  assign bus.wbm_sel_o = sel_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_dat   = rsp_dat_r;
  assign bus.rsp_err   = rsp_err_r;

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= '0;
      dat_r       <= '0;
      sel_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state       <= next_state;
      cyc_r       <= cyc_nxt;
      we_r        <= we_nxt;
      adr_r       <= adr_nxt;
      dat_r       <= dat_nxt;
      sel_r       <= sel_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_dat_r   <= rsp_dat_nxt;
      rsp_err_r   <= rsp_err_nxt;
    end
  end

  // Next-state decode; ack is only looked at while in BUS
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_BUS;
        else        next_state = ST_IDLE;
      end
      ST_BUS: begin
        if (bus.wbm_ack_i || timed_out) next_state = ST_RESP;
        else                            next_state = ST_BUS;
      end
      ST_RESP: begin
        if (bus.rsp_ready) next_state = ST_IDLE;
        else               next_state = ST_RESP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs
  always_comb begin
    cyc_nxt       = cyc_r;
    we_nxt        = we_r;
    adr_nxt       = adr_r;
    dat_nxt       = dat_r;
    sel_nxt       = sel_r;
    rsp_valid_nxt = rsp_valid_r;
    rsp_dat_nxt   = rsp_dat_r;
    rsp_err_nxt   = rsp_err_r;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cyc_nxt = 1'b1;
          we_nxt  = bus.cmd_we;
          adr_nxt = bus.cmd_adr;
          dat_nxt = bus.cmd_we ? bus.cmd_dat : '0;
          sel_nxt = bus.cmd_sel;
        end else begin
          cyc_nxt = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus.wbm_ack_i || timed_out) begin
          cyc_nxt       = 1'b0;
          we_nxt        = 1'b0;
          adr_nxt       = '0;
          dat_nxt       = '0;
          sel_nxt       = '0;
          rsp_valid_nxt = 1'b1;
          // Write and timeout completions carry no data
          rsp_dat_nxt   = (bus.wbm_ack_i && !we_r) ? bus.wbm_dat_i : '0;
          rsp_err_nxt   = !bus.wbm_ack_i;
        end else begin
          cyc_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) rsp_valid_nxt = 1'b0;
        else               rsp_valid_nxt = 1'b1;
      end
      default: begin
        cyc_nxt       = 1'b0;
        we_nxt        = 1'b0;
        adr_nxt       = '0;
        dat_nxt       = '0;
        sel_nxt       = '0;
        rsp_valid_nxt = 1'b0;
        rsp_dat_nxt   = '0;
        rsp_err_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a behavioural register slave
// (registered-ack, combinational-ack or silent), a word-level reference
// memory, and a monitor that checks every response against the queue.
module tb_wb_cmd_master;
  import wbm_pkg::*;

  localparam int T_CYC = 16;
  localparam int M_REG = 0;
  localparam int M_COMB = 1;
  localparam int M_NEVER = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  wb_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T_CYC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int slave_mode = M_REG;
  logic [31:0] slv_mem [16] = '{default: 32'h0};
  logic        ack_reg = 1'b0;
  logic [31:0] dat_reg = 32'h0;
  logic        slv_wr;

  assign slv_wr = bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_we_o &&
                  ((slave_mode == M_REG && !ack_reg) || slave_mode == M_COMB);
  assign bus.wbm_ack_i = (slave_mode == M_COMB) ? (bus.wbm_cyc_o && bus.wbm_stb_o) :
                         (slave_mode == M_REG) ? ack_reg : 1'b0;
  assign bus.wbm_dat_i = (slave_mode == M_COMB) ? slv_mem[bus.wbm_adr_o[5:2]] : dat_reg;

  always @(posedge clk) begin
    ack_reg <= (slave_mode == M_REG) && bus.wbm_cyc_o && bus.wbm_stb_o;
    if (slave_mode == M_REG && bus.wbm_cyc_o && bus.wbm_stb_o && !ack_reg)
      dat_reg <= slv_mem[bus.wbm_adr_o[5:2]];
    if (slv_wr)
      for (int b = 0; b < 4; b++)
        if (bus.wbm_sel_o[b]) slv_mem[bus.wbm_adr_o[5:2]][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
  end

  // ---------------- response-ready driver ----------------
  int rr_mode = 0;  // 0: always ready, 1: random, 2: hold low 10 cycles
  int bp_cnt = 0;
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0) bus.rsp_ready = 1'b1;
      else if (rr_mode == 1) bus.rsp_ready = 1'($urandom_range(0, 1));
      else if (bus.rsp_valid && bp_cnt < 10) begin bus.rsp_ready = 1'b0; bp_cnt++; end
      else if (bus.rsp_valid) bus.rsp_ready = 1'b1;
      else begin bus.rsp_ready = 1'b0; bp_cnt = 0; end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  // ---------------- monitor ----------------
  exp_t mon_e;
  logic prev_valid = 1'b0, prev_ready = 1'b0, hs_prev = 1'b0;
  logic [31:0] held_dat = 32'h0;
  logic held_err = 1'b0;
  int cyc_hi = 0;
  int last_hs_edge = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0; prev_ready = 1'b0; hs_prev = 1'b0; cyc_hi = 0;
    end else begin
      if (bus.wbm_cyc_o) cyc_hi++;
      if (bus.wbm_cyc_o || bus.wbm_stb_o) check("cyc_eq_stb", bus.wbm_stb_o, bus.wbm_cyc_o);
      if (hs_prev) check("rsp_single_pulse", bus.rsp_valid, 1'b0);
      if (bus.rsp_valid) begin
        check("cmd_ready_low_in_resp", bus.cmd_ready, 1'b0);
        check("busy_in_resp", busy, 1'b1);
      end
      if (bus.rsp_valid && !prev_valid) begin
        check("rsp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q[0];
          check("latency", cycle - mon_e.acc, mon_e.lat);
          check("cyc_high_cycles", cyc_hi, mon_e.lat);
        end
        cyc_hi = 0;
      end else if (bus.rsp_valid && prev_valid && !prev_ready) begin
        check("rsp_dat_stable", bus.rsp_dat, held_dat);
        check("rsp_err_stable", bus.rsp_err, held_err);
      end
      hs_prev = bus.rsp_valid && bus.rsp_ready;
      if (hs_prev) begin
        last_hs_edge = cycle + 1;
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_dat", bus.rsp_dat, mon_e.dat);
          check("rsp_err", bus.rsp_err, mon_e.err);
        end
      end
      held_dat = bus.rsp_dat;
      held_err = bus.rsp_err;
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
    end
  end

  // ---------------- stimulus ----------------
  // Present a command (caller is just after a rising edge), wait for the
  // accepting edge, push the expected response and drop cmd_valid.
  task automatic issue(input logic we, input int idx, input logic [31:0] dat,
                       input logic [3:0] sel, input int mode, output int acc);
    exp_t e;
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we = we;
    bus.cmd_adr = UP_BASE + 32'(idx * 4);
    bus.cmd_dat = dat;
    bus.cmd_sel = sel;
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
    end
    check("cmd_accept_bound", ok, 1'b1);
    acc = cycle + 1;
    if (ok) begin
      slave_mode = mode;
      e.acc = acc;
      e.err = (mode == M_NEVER);
      e.lat = (mode == M_NEVER) ? T_CYC : (mode == M_COMB) ? 1 : 2;
      e.dat = 32'h0;
      if (mode != M_NEVER && we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end else if (mode != M_NEVER) begin
        e.dat = ref_mem[idx];
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() > 0 && b < 500) begin @(negedge clk); b++; end
    check("drain_bound", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int acc, acc_b, nmodes;
    bit ok;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = 32'h0;
    bus.cmd_dat = 32'h0; bus.cmd_sel = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_dat", bus.rsp_dat, 32'h0);
    check("rst_wbm", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 7'h0);
    check("rst_wbm_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'h0);
    check("rst_busy", busy, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Registered-ack write to PWM0 rise
    rr_mode = 0;
    issue(1'b1, 0, 32'h0000_0080, 4'hF, M_REG, acc);
    drain();
    check("pwm0_rise_readback", slv_mem[0], 32'h80);

    // Read of PWM0 fall holding 0xAA553311 (echo ack must stay silent)
    @(posedge clk); #1;
    issue(1'b1, 1, 32'hAA55_3311, 4'hF, M_REG, acc);
    issue(1'b0, 1, 32'hFFFF_FFFF, 4'hF, M_REG, acc);
    drain();

    // Back-pressure with the next command waiting
    @(posedge clk); #1;
    rr_mode = 2;
    issue(1'b1, 4, 32'h1234_5678, 4'hF, M_REG, acc);
    issue(1'b0, 4, 32'h0, 4'hF, M_REG, acc_b);
    check("b2b_accept_edge", acc_b, last_hs_edge + 1);
    drain();
    rr_mode = 0;

    // Zero-wait slave: write then read PWM1 rise
    @(posedge clk); #1;
    issue(1'b1, 2, 32'hC0DE_1234, 4'hF, M_COMB, acc);
    issue(1'b0, 2, 32'h0, 4'hF, M_COMB, acc);
    drain();

`ifdef WBM_TIMEOUT_EN
    // Silent slave on CTRL: forced error completion
    @(posedge clk); #1;
    issue(1'b0, 15, 32'h0, 4'hF, M_NEVER, acc);
    drain();
    check("busy_after_timeout", busy, 1'b0);
`endif

    // Reset one cycle into BUS
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_adr = UP_BASE + 32'd8; bus.cmd_sel = 4'hF;
    ok = 0;
    for (int b = 0; b < 300; b++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
    end
    check("rst_test_accept", ok, 1'b1);
    slave_mode = M_REG;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("rst_test_in_bus", bus.wbm_cyc_o, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_async_cyc", bus.wbm_cyc_o, 1'b0);
    check("rst_async_stb", bus.wbm_stb_o, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    check("rst_release_ready", bus.cmd_ready, 1'b1);

    // Randomized traffic
    @(posedge clk); #1;
`ifdef WBM_TIMEOUT_EN
    nmodes = 3;
`else
    nmodes = 2;
`endif
    for (int i = 0; i < 120; i++) begin
      int mode;
      rr_mode = $urandom_range(0, 1);
      mode = $urandom_range(0, 9);
      if (mode == 9 && nmodes == 3) mode = M_NEVER;
      else mode = mode % 2;
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
            4'($urandom_range(0, 15)), mode, acc);
    end
    rr_mode = 0;
    drain();
    check("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
